// File: rtl/sync_regfile_n.sv
// Register file with a two-stage write path (capture, then commit), two independent
// tri-state read ports and optional forwarding of the pending write to the readers.
module sync_regfile_n #(
    parameter int LOG    = 0,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             _MR,
    input  logic             _wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             _rdL_en,
    input  logic [AW-1:0]    rdL_addr,
    output logic [WIDTH-1:0] rdL_data,
    input  logic             _rdR_en,
    input  logic [AW-1:0]    rdR_addr,
    output logic [WIDTH-1:0] rdR_data,
    output logic             wr_pending
);

    // LOG only controls simulation-side logging; the block itself emits no messages.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LOG > 1) || (LOG < 0) ||
        (BYPASS > 1) || (BYPASS < 0) || (WIDTH < 1)) begin : g_bad_param
        $error("sync_regfile_n: illegal parameter combination");
    end

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic             pend_valid_r;
    logic [AW-1:0]    pend_addr_r;
    logic [WIDTH-1:0] pend_data_r;
    logic [WIDTH-1:0] rdl_s;
    logic [WIDTH-1:0] rdr_s;

    // Capture the incoming write and commit the previously captured one on the same edge.
    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {AW{1'b0}};
            pend_data_r  <= {WIDTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pend_valid_r <= ~_wr_en;
            pend_addr_r  <= wr_addr;
            pend_data_r  <= wr_data;
            if (pend_valid_r) begin
                regs_r[pend_addr_r] <= pend_data_r;
            end else begin
                regs_r[pend_addr_r] <= regs_r[pend_addr_r];
            end
        end
    end

    // Left read: the pending write shadows the array entry it will overwrite.
    always_comb begin
        rdl_s = regs_r[rdL_addr];
        if ((BYPASS != 0) && pend_valid_r && (pend_addr_r == rdL_addr)) begin
            rdl_s = pend_data_r;
        end else begin
            rdl_s = regs_r[rdL_addr];
        end
    end

    // Right read: same selection as the left port, fully independent.
    always_comb begin
        rdr_s = regs_r[rdR_addr];
        if ((BYPASS != 0) && pend_valid_r && (pend_addr_r == rdR_addr)) begin
            rdr_s = pend_data_r;
        end else begin
            rdr_s = regs_r[rdR_addr];
        end
    end

    assign rdL_data   = _rdL_en ? {WIDTH{1'bz}} : rdl_s;
    assign rdR_data   = _rdR_en ? {WIDTH{1'bz}} : rdr_s;
    assign wr_pending = pend_valid_r;

endmodule

// File: tb/tb_sync_regfile_n.sv
// Directed bench for sync_regfile_n: bypassing, non-bypassing and 16x16 instances,
// with expected values queued in a scoreboard and compared at each sample point.
module tb_sync_regfile_n;

    logic        clk;
    logic        mr;
    // shared stimulus for the two 8-bit/4-entry instances
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rdl_en;
    logic [1:0]  rdl_addr;
    logic        rdr_en;
    logic [1:0]  rdr_addr;
    wire  [7:0]  a_rdl;
    wire  [7:0]  a_rdr;
    wire         a_pend;
    wire  [7:0]  b_rdl;
    wire  [7:0]  b_rdr;
    wire         b_pend;
    // stimulus for the 16-bit/16-entry instance
    logic        c_wr_en;
    logic [3:0]  c_wr_addr;
    logic [15:0] c_wr_data;
    logic        c_rdl_en;
    logic [3:0]  c_rdl_addr;
    logic        c_rdr_en;
    logic [3:0]  c_rdr_addr;
    wire  [15:0] c_rdl;
    wire  [15:0] c_rdr;
    wire         c_pend;

    int total;
    int bad;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    sync_regfile_n #(.LOG(0), .WIDTH(8), .DEPTH(4), .BYPASS(1)) dut (
        .clk(clk), ._MR(mr), ._wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        ._rdL_en(rdl_en), .rdL_addr(rdl_addr), .rdL_data(a_rdl),
        ._rdR_en(rdr_en), .rdR_addr(rdr_addr), .rdR_data(a_rdr), .wr_pending(a_pend)
    );

    sync_regfile_n #(.LOG(0), .WIDTH(8), .DEPTH(4), .BYPASS(0)) dut_nb (
        .clk(clk), ._MR(mr), ._wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        ._rdL_en(rdl_en), .rdL_addr(rdl_addr), .rdL_data(b_rdl),
        ._rdR_en(rdr_en), .rdR_addr(rdr_addr), .rdR_data(b_rdr), .wr_pending(b_pend)
    );

    sync_regfile_n #(.LOG(0), .WIDTH(16), .DEPTH(16), .BYPASS(1)) dut_w (
        .clk(clk), ._MR(mr), ._wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        ._rdL_en(c_rdl_en), .rdL_addr(c_rdl_addr), .rdL_data(c_rdl),
        ._rdR_en(c_rdr_en), .rdR_addr(c_rdr_addr), .rdR_data(c_rdr), .wr_pending(c_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [15:0] obs);
        logic [15:0] e;
        string t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        mr = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h00;
        rdl_en = 1'b0; rdl_addr = 2'd0; rdr_en = 1'b0; rdr_addr = 2'd0;
        c_wr_en = 1'b1; c_wr_addr = 4'd0; c_wr_data = 16'h0000;
        c_rdl_en = 1'b0; c_rdl_addr = 4'd0; c_rdr_en = 1'b0; c_rdr_addr = 4'd0;

        // reset state before any clock edge
        #3;
        expect_val("rst_pend_a", 16'h0000); chk({15'h0000, a_pend});
        expect_val("rst_pend_b", 16'h0000); chk({15'h0000, b_pend});
        expect_val("rst_pend_c", 16'h0000); chk({15'h0000, c_pend});
        for (int i = 0; i < 4; i++) begin
            rdl_addr = 2'(i);
            #1;
            expect_val("rst_rd_a", 16'h0000); chk({8'h00, a_rdl});
            expect_val("rst_rd_b", 16'h0000); chk({8'h00, b_rdl});
        end

        // capture suppressed while reset is held
        wr_en = 1'b0; wr_addr = 2'd1; wr_data = 8'h77;
        tick();
        expect_val("rst_no_capture", 16'h0000); chk({15'h0000, a_pend});
        wr_en = 1'b1;
        @(negedge clk);
        mr = 1'b1;

        // single write, read in the following cycle
        wr_en = 1'b0; wr_addr = 2'd2; wr_data = 8'hA5;
        tick();
        wr_en = 1'b1; rdl_addr = 2'd2; rdr_addr = 2'd2;
        #1;
        expect_val("byp_rd_a", 16'h00A5);   chk({8'h00, a_rdl});
        expect_val("byp_pend_a", 16'h0001); chk({15'h0000, a_pend});
        expect_val("nobyp_rd_b", 16'h0000); chk({8'h00, b_rdl});
        expect_val("nobyp_pend_b", 16'h0001); chk({15'h0000, b_pend});
        tick();
        expect_val("commit_rd_a", 16'h00A5);  chk({8'h00, a_rdl});
        expect_val("commit_rdr_a", 16'h00A5); chk({8'h00, a_rdr});
        expect_val("commit_pend_a", 16'h0000); chk({15'h0000, a_pend});
        expect_val("commit_rd_b", 16'h00A5);  chk({8'h00, b_rdl});

        // back-to-back writes
        wr_en = 1'b0; wr_addr = 2'd1; wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        rdl_addr = 2'd1;
        #1;
        expect_val("b2b_mid_a", 16'h0022); chk({8'h00, a_rdl});
        expect_val("b2b_mid_b", 16'h0011); chk({8'h00, b_rdl});
        wr_addr = 2'd3; wr_data = 8'h33;
        tick();
        wr_en = 1'b1;
        tick();
        rdr_addr = 2'd3;
        #1;
        expect_val("b2b_l_a", 16'h0022); chk({8'h00, a_rdl});
        expect_val("b2b_r_a", 16'h0033); chk({8'h00, a_rdr});
        expect_val("b2b_l_b", 16'h0022); chk({8'h00, b_rdl});
        expect_val("b2b_r_b", 16'h0033); chk({8'h00, b_rdr});
        rdl_addr = 2'd2;
        #1;
        expect_val("b2b_keep2", 16'h00A5); chk({8'h00, a_rdl});

        // disabled read port floats
        rdr_en = 1'b1;
        #1;
        total++;
        assert (a_rdr === 8'hzz) else begin
            bad++;
            $error("FAIL tri_a: observed=%h expected=zz", a_rdr);
        end
        total++;
        assert (b_rdr === 8'hzz) else begin
            bad++;
            $error("FAIL tri_b: observed=%h expected=zz", b_rdr);
        end
        rdr_en = 1'b0;

        // reset aborts an uncommitted write, mid-cycle, without a clock edge
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'hFF;
        tick();
        wr_en = 1'b1; rdl_addr = 2'd0;
        #1;
        expect_val("abort_pre_rd", 16'h00FF);  chk({8'h00, a_rdl});
        expect_val("abort_pre_pend", 16'h0001); chk({15'h0000, a_pend});
        #2;
        mr = 1'b0;
        #1;
        expect_val("abort_pend_a", 16'h0000); chk({15'h0000, a_pend});
        for (int i = 0; i < 4; i++) begin
            rdl_addr = 2'(i);
            #1;
            expect_val("abort_rd_a", 16'h0000); chk({8'h00, a_rdl});
        end
        tick();
        @(negedge clk);
        mr = 1'b1;

        // first edge after reset release captures normally
        wr_en = 1'b0; wr_addr = 2'd3; wr_data = 8'h5A;
        tick();
        wr_en = 1'b1; rdl_addr = 2'd3; rdr_addr = 2'd0;
        #1;
        expect_val("rel_rd_a", 16'h005A);  chk({8'h00, a_rdl});
        expect_val("rel_pend_a", 16'h0001); chk({15'h0000, a_pend});
        expect_val("rel_reg0_a", 16'h0000); chk({8'h00, a_rdr});
        tick();
        expect_val("rel_commit_a", 16'h005A); chk({8'h00, a_rdl});
        expect_val("rel_commit_b", 16'h005A); chk({8'h00, b_rdl});

        // wide/deep instance: top and bottom addresses
        c_wr_en = 1'b0; c_wr_addr = 4'd15; c_wr_data = 16'hA5A5;
        tick();
        c_wr_en = 1'b1; c_rdl_addr = 4'd15; c_rdr_addr = 4'd0;
        #1;
        expect_val("w_byp_rd", 16'hA5A5);  chk(c_rdl);
        expect_val("w_byp_pend", 16'h0001); chk({15'h0000, c_pend});
        expect_val("w_byp_reg0", 16'h0000); chk(c_rdr);
        tick();
        expect_val("w_commit_rd", 16'hA5A5);  chk(c_rdl);
        expect_val("w_commit_pend", 16'h0000); chk({15'h0000, c_pend});
        expect_val("w_commit_reg0", 16'h0000); chk(c_rdr);

        c_wr_en = 1'b0; c_wr_addr = 4'd0; c_wr_data = 16'h1111;
        tick();
        c_wr_data = 16'h2222;
        tick();
        c_rdl_addr = 4'd0;
        #1;
        expect_val("w_b2b_mid", 16'h2222); chk(c_rdl);
        c_wr_addr = 4'd15; c_wr_data = 16'h3333;
        tick();
        c_wr_en = 1'b1;
        tick();
        c_rdr_addr = 4'd15;
        #1;
        expect_val("w_b2b_l", 16'h2222); chk(c_rdl);
        expect_val("w_b2b_r", 16'h3333); chk(c_rdr);
        c_rdr_en = 1'b1;
        #1;
        total++;
        assert (c_rdr === 16'hzzzz) else begin
            bad++;
            $error("FAIL tri_w: observed=%h expected=zzzz", c_rdr);
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
